// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared encodings for the two-port memory arbiter: FSM state
//               codes and requester port identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // FSM state encoding (explicit 1-bit width)
    localparam logic [0:0] ST_IDLE = 1'b0;  // no transaction outstanding
    localparam logic [0:0] ST_WAIT = 1'b1;  // one transaction outstanding

    // Requester identifiers, also used as the owner / last-served encoding
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational 2-way round-robin picker. When both requests
//               are high, the port that was not served last wins.
// Ports       : req[1:0]   - request vector (bit 0 = A, bit 1 = B)
//               last       - port served most recently
//               grant[1:0] - one-hot grant, zero when no request
//               winner     - id of the granted port (don't-care if none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = PORT_A;
        grant  = 2'b00;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = PORT_B;
        end
        if (|req) begin
            grant = (winner == PORT_B) ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of one delayed byte
//               memory (doit/busy/rvalid handshake). Tracks a single
//               outstanding transaction and returns completion and read data
//               to the port that owns it.
// Ports       : clk, init (async active-high reset)
//               a_* / b_* : requester ports (req/addr/wdata/wselect in,
//                           gnt/done/rdata out)
//               m_*       : memory port (addr/wdata/wselect/doit out,
//                           busy/rvalid/rdata in)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LOGSIZE = 1
) (
    input  logic               clk,
    input  logic               init,
    input  logic               a_req,
    input  logic [LOGSIZE-1:0] a_addr,
    input  logic [7:0]         a_wdata,
    input  logic               a_wselect,
    output logic               a_gnt,
    output logic               a_done,
    output logic [7:0]         a_rdata,
    input  logic               b_req,
    input  logic [LOGSIZE-1:0] b_addr,
    input  logic [7:0]         b_wdata,
    input  logic               b_wselect,
    output logic               b_gnt,
    output logic               b_done,
    output logic [7:0]         b_rdata,
    output logic [LOGSIZE-1:0] m_addr,
    output logic [7:0]         m_wdata,
    output logic               m_wselect,
    output logic               m_doit,
    input  logic               m_busy,
    input  logic               m_rvalid,
    input  logic [7:0]         m_rdata
);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       r_owner;
    logic       r_owner_wr;
    logic       r_last;
    logic [7:0] r_rdata;

    logic [1:0] w_grant;
    logic       w_winner;
    logic       w_issue;
    logic       w_complete;

    rr_pick2 u_pick (
        .req    ({b_req, a_req}),
        .last   (r_last),
        .grant  (w_grant),
        .winner (w_winner)
    );

    // Issue is legal in IDLE and in the completion cycle of WAIT; both reduce
    // to "memory not busy". A busy memory in IDLE (stale op after reset) thus
    // blocks issue as well. init gates everything so outputs are 0 in reset.
    assign w_issue    = !init && !m_busy && (a_req || b_req);

    // Completion is the first WAIT cycle with busy low. done is derived from
    // the registered owner/state so it pulses exactly in that cycle, which is
    // also the cycle a back-to-back issue may happen.
    assign w_complete = !init && (r_state == ST_WAIT) && !m_busy;

    always_comb begin
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        m_doit      = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_wselect   = 1'b0;
        w_state_nxt = r_state;

        if (w_issue) begin
            a_gnt  = w_grant[0];
            b_gnt  = w_grant[1];
            m_doit = 1'b1;
            if (w_winner == PORT_B) begin
                m_addr    = b_addr;
                m_wdata   = b_wdata;
                m_wselect = b_wselect;
            end else begin
                m_addr    = a_addr;
                m_wdata   = a_wdata;
                m_wselect = a_wselect;
            end
            w_state_nxt = ST_WAIT;
        end else if (w_complete) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign a_done  = w_complete && (r_owner == PORT_A);
    assign b_done  = w_complete && (r_owner == PORT_B);
    assign a_rdata = r_rdata;
    assign b_rdata = r_rdata;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state    <= ST_IDLE;
            r_owner    <= PORT_A;
            r_owner_wr <= 1'b0;
            r_last     <= PORT_B;
            r_rdata    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_owner    <= w_winner;
                r_owner_wr <= m_wselect;
                r_last     <= w_winner;
            end
            // rvalid outside a read transaction belongs to nobody; drop it.
            if ((r_state == ST_WAIT) && m_rvalid && !r_owner_wr) begin
                r_rdata <= m_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a 3-step
//               delayed byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LOGSIZE = 4;
    localparam int STEPS   = 3;

    logic               clk = 1'b0;
    logic               init;
    logic               a_req, b_req, a_wselect, b_wselect;
    logic [LOGSIZE-1:0] a_addr, b_addr;
    logic [7:0]         a_wdata, b_wdata;
    logic               a_gnt, a_done, b_gnt, b_done;
    logic [7:0]         a_rdata, b_rdata;
    logic [LOGSIZE-1:0] m_addr;
    logic [7:0]         m_wdata;
    logic               m_wselect, m_doit, m_busy, m_rvalid;
    logic [7:0]         m_rdata;

    // memory model state
    logic [7:0]         mem [16];
    logic               mem_busy, force_busy, op_wr;
    logic [LOGSIZE-1:0] op_addr;
    int                 cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign m_busy = mem_busy | force_busy;

    mem_arbiter #(.LOGSIZE(LOGSIZE)) dut (
        .clk(clk), .init(init),
        .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_wselect(a_wselect),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_wselect(b_wselect),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wselect(m_wselect), .m_doit(m_doit),
        .m_busy(m_busy), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    // Delayed memory: busy T+1..T+STEPS, rvalid at T+STEPS for reads.
    // It ignores init so an abandoned operation keeps running.
    always @(posedge clk) begin
        m_rvalid <= 1'b0;
        if (m_doit) begin
            mem_busy <= 1'b1;
            cnt      <= STEPS;
            op_addr  <= m_addr;
            op_wr    <= m_wselect;
            if (m_wselect) mem[m_addr] <= m_wdata;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) mem_busy <= 1'b0;
            if (cnt == 2 && !op_wr) begin
                m_rvalid <= 1'b1;
                m_rdata  <= mem[op_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs are driven mid-cycle, checks 1ns later
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[3] = 8'h5A;
        mem_busy = 1'b0; force_busy = 1'b0; cnt = 0; op_wr = 1'b0; op_addr = '0;
        m_rvalid = 1'b0; m_rdata = 8'h00;
        a_req = 0; b_req = 0; a_addr = '0; b_addr = '0;
        a_wdata = '0; b_wdata = '0; a_wselect = 0; b_wselect = 0;

        // ---------------- reset state ----------------
        init = 1'b1;
        a_req = 1'b1; a_addr = 4'd3;
        cyc(); settle();
        chk("rst_gnt",   8'({a_gnt, b_gnt}), 8'h00);
        chk("rst_doit",  8'(m_doit), 8'h00);
        chk("rst_done",  8'({a_done, b_done}), 8'h00);
        chk("rst_rdata", a_rdata, 8'h00);
        cyc(); init = 1'b0; a_req = 1'b0;

        // ---------------- single read A @3 ----------------
        cyc(); a_req = 1'b1; a_addr = 4'd3; a_wselect = 1'b0; settle();
        chk("rd_a_gnt",  8'(a_gnt), 8'h01);
        chk("rd_doit",   8'(m_doit), 8'h01);
        chk("rd_maddr",  8'(m_addr), 8'h03);
        cyc(); a_req = 1'b0; settle();
        chk("rd_done_t1", 8'(a_done), 8'h00);
        cyc(); cyc(); settle();
        chk("rd_done_t3", 8'(a_done), 8'h00);
        cyc(); settle();
        chk("rd_done_t4", 8'(a_done), 8'h01);
        chk("rd_bdone",   8'(b_done), 8'h00);
        chk("rd_rdata",   a_rdata, 8'h5A);
        cyc(); settle();
        chk("rd_done_t5", 8'(a_done), 8'h00);

        // ---------------- B write 0xC3 @7, then read @7 ----------------
        cyc(); b_req = 1'b1; b_addr = 4'd7; b_wdata = 8'hC3; b_wselect = 1'b1; settle();
        chk("wr_b_gnt", 8'(b_gnt), 8'h01);
        chk("wr_wsel",  8'(m_wselect), 8'h01);
        chk("wr_wdata", m_wdata, 8'hC3);
        cyc(); b_wselect = 1'b0; b_wdata = 8'h00; settle();
        chk("wr_nogrant_busy", 8'(b_gnt), 8'h00);
        cyc(); cyc(); cyc(); settle();
        chk("wr_b_done",  8'(b_done), 8'h01);
        chk("b2b_b_gnt",  8'(b_gnt), 8'h01);
        chk("b2b_wsel",   8'(m_wselect), 8'h00);
        cyc(); b_req = 1'b0; cyc(); cyc(); cyc(); settle();
        chk("rb_b_done", 8'(b_done), 8'h01);
        chk("rb_rdata",  b_rdata, 8'hC3);

        // ---------------- contention after reset ----------------
        cyc(); init = 1'b1; settle();
        cyc(); init = 1'b0;
        a_req = 1'b1; a_addr = 4'd3; a_wselect = 1'b0;
        b_req = 1'b1; b_addr = 4'd7; b_wselect = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin cyc(); cyc(); cyc(); cyc(); end
            settle();
            chk("ct_gnt", 8'({b_gnt, a_gnt}), (k % 2 == 0) ? 8'h01 : 8'h02);
            if (k > 0) begin
                chk("ct_done", 8'({b_done, a_done}), (k % 2 == 1) ? 8'h01 : 8'h02);
                chk("ct_rdata", a_rdata, (k % 2 == 1) ? 8'h5A : 8'hC3);
            end
        end
        cyc(); a_req = 1'b0; b_req = 1'b0; cyc(); cyc(); cyc(); settle();
        chk("ct_last_done",  8'({b_done, a_done}), 8'h02);
        chk("ct_last_rdata", b_rdata, 8'hC3);

        // ---------------- busy high while idle blocks issue ----------------
        cyc(); force_busy = 1'b1; a_req = 1'b1; a_addr = 4'd3; settle();
        chk("bz_gnt0",  8'(a_gnt), 8'h00);
        chk("bz_doit0", 8'(m_doit), 8'h00);
        cyc(); cyc(); settle();
        chk("bz_gnt2",  8'({a_gnt, m_doit}), 8'h00);
        cyc(); force_busy = 1'b0; settle();
        chk("bz_gnt_rel", 8'({a_gnt, m_doit}), 8'h03);
        cyc(); a_req = 1'b0; cyc(); cyc(); cyc(); settle();
        chk("bz_done",  8'(a_done), 8'h01);
        chk("bz_rdata", a_rdata, 8'h5A);

        // ---------------- reset in the middle of an A read @7 ----------------
        cyc(); a_req = 1'b1; a_addr = 4'd7; settle();
        chk("mr_gnt", 8'(a_gnt), 8'h01);
        cyc(); a_req = 1'b0;
        cyc(); init = 1'b1; settle();
        chk("mr_outs", 8'({a_gnt, b_gnt, a_done, b_done, m_doit, m_wselect}), 8'h00);
        chk("mr_rdata", a_rdata, 8'h00);
        cyc(); init = 1'b0; settle();
        chk("mr_done_t3", 8'(a_done), 8'h00);
        cyc(); settle();
        chk("mr_done_t4", 8'(a_done), 8'h00);
        chk("mr_stale",   a_rdata, 8'h00);
        a_req = 1'b1; a_addr = 4'd3; settle();
        chk("mr_regrant", 8'(a_gnt), 8'h01);
        cyc(); a_req = 1'b0; cyc(); cyc(); cyc(); settle();
        chk("mr_done", 8'(a_done), 8'h01);
        chk("mr_data", a_rdata, 8'h5A);

        // ---------------- A write 0x01 @2 ----------------
        cyc(); a_req = 1'b1; a_addr = 4'd2; a_wdata = 8'h01; a_wselect = 1'b1; settle();
        chk("wa_gnt", 8'(a_gnt), 8'h01);
        cyc(); a_req = 1'b0; a_wselect = 1'b0; cyc(); cyc(); settle();
        chk("wa_done_t3", 8'(a_done), 8'h00);
        cyc(); settle();
        chk("wa_done_t4", 8'(a_done), 8'h01);
        chk("wa_rdata",   a_rdata, 8'h5A);
        chk("wa_mem",     mem[2], 8'h01);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // safety bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing one delayed byte memory (the `doit`/`busy`/`rvalid` memory model) between two requesters, e.g. instruction fetch (port A) and tape access (port B) in the BF core. It accepts one request at a time and drives it onto the memory port in the same cycle. It tracks the single outstanding transaction and returns completion and read data to the owning port. It does not reorder, pipeline or buffer more than one transaction.

## Interface
Parameters:
- `LOGSIZE`, default 1: address width, matching the memory's `logsize`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `init`  in  1  reset, asynchronous, active-high.
- `a_req`  in  1  port A request; level, held until `a_gnt`.
- `a_addr`  in  LOGSIZE  port A address; stable while `a_req` is high.
- `a_wdata`  in  8  port A write data.
- `a_wselect`  in  1  port A: 1 = write, 0 = read.
- `a_gnt`  out  1  port A request issued this cycle (combinational pulse).
- `a_done`  out  1  port A transaction complete (registered pulse).
- `a_rdata`  out  8  port A read data; valid when `a_done` is high and the transaction was a read.
- `b_req`, `b_addr`, `b_wdata`, `b_wselect`, `b_gnt`, `b_done`, `b_rdata`: identical to port A.
- `m_addr`  out  LOGSIZE  memory address.
- `m_wdata`  out  8  memory write data.
- `m_wselect`  out  1  memory write select.
- `m_doit`  out  1  memory command strobe.
- `m_busy`  in  1  memory busy.
- `m_rvalid`  in  1  memory read-valid pulse.
- `m_rdata`  in  8  memory read data; sampled only when `m_rvalid` is high.

## Operation
- State machine with two states.
  - **IDLE**: no transaction outstanding.
  - **WAIT**: one transaction outstanding. Registers `owner` (0 = A, 1 = B) and `owner_wr` (the write flag).
- Issue happens when the FSM is in IDLE, or in WAIT with `m_busy == 0` (completion cycle), and at least one request is high and `m_busy == 0`.
  - Winner: if only one port requests, that port wins.
  - If both request, the port not served last wins.
  - `last` resets to B, so A wins the first tie.
- On issue:
  - `m_doit = 1`; `m_addr`/`m_wdata`/`m_wselect` come from the winner, combinationally.
  - Winner's `gnt` = 1.
  - Next state is WAIT; `owner`, `owner_wr` and `last` are updated.
- When not issuing, `m_doit = 0` and the `m_*` data outputs are zero.
- In WAIT:
  - When `m_rvalid` is high and `owner_wr == 0`, `m_rdata` is captured into a `rdata` register.
  - When `m_busy == 0`, the owner's `done` is pulsed for one cycle from a registered flag. Next state is WAIT if a new issue happens in the same cycle, else IDLE.
- `a_rdata`/`b_rdata` both present the `rdata` register. It is meaningful only with the owning `done` pulse.
- `m_rvalid` in IDLE, or during a write transaction, is ignored.
- `m_busy == 1` in IDLE (for example a stale operation after reset) blocks issue; no `gnt` is given.
- Reset (async, any time, including mid-transaction):
  - State IDLE, `last = B`, `rdata = 0`, the done flags cleared.
  - All outputs 0 while `init` is high.
  - An in-flight memory operation is abandoned; its `rvalid` is ignored.
- Memory `steps` must be at least 1.

## Timing
- Issue at cycle T, memory `steps = S`:
  - `m_busy` high T+1..T+S.
  - `m_rvalid` at T+S for a read.
  - `done` at T+S+1, with `rdata` valid for a read.
- Write completion has the same timing as a read: `done` at T+S+1.
- Back-to-back: the next issue may occur in the same cycle T+S+1 as the previous `done`. Throughput is one transaction per S+1 cycles.
- `gnt` is the same cycle as issue. The requester may drop or change `req` from T+1.
- A `req` rising in a cycle where issue is possible is granted that same cycle (zero-latency grant).

## Structure
- Shared package holds:
  - State encoding (`ST_IDLE`, `ST_WAIT`).
  - Port ids (`PORT_A = 0`, `PORT_B = 1`).
- One natural sub-module, `rr_pick2`: combinational 2-way round-robin picker. Inputs: `req[2]`, `last`. Outputs: `grant[2]` (one-hot or zero), `winner`.
- Top holds the FSM, the owner/last/rdata registers and the output muxing.

## Test plan
Bench uses LOGSIZE = 4 and memory `steps = 3`.
- Single read, memory holds 0x5A at address 3. A reads address 3 at T → `a_gnt` at T, `m_doit` at T, `a_done` at T+4 with `a_rdata = 0x5A`. `b_done` never asserts.
- Write then read. B writes 0xC3 to address 7, then B reads address 7 → second `b_gnt` coincides with the first `b_done`. Read returns 0xC3.
- Contention. A and B both hold `req` continuously with reads after reset → grants alternate A, B, A, B, each 4 cycles apart. Each `done` goes to the correct port with its own data.
- `m_busy` forced high while idle and `a_req` high → no `a_gnt` and no `m_doit` until `m_busy` drops. Grant is in the first cycle `m_busy` is low.
- Reset mid-read. Assert `init` at T+2 of an A read → all outputs 0 immediately. No `a_done` follows. The stale `m_rvalid` is ignored and the next request is served normally.
- Write completion. A writes 0x01 → `a_done` at T+4. `a_rdata` is unchanged from its prior value.
